// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the N-input AXI-Stream packet arbiter.
package axis_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic ARB_RR   = 1'b0;
    localparam logic ARB_PRIO = 1'b1;

    // Width of a channel index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_arb_grant_sel.sv
// Combinational winner selection: rotating priority (round-robin) or lowest-index priority.
module axis_arb_grant_sel
    import axis_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ID_W   = id_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   last_grant,
    input  logic              mode,
    output logic [ID_W-1:0]   winner,
    output logic              any_req
);

    logic [ID_W:0] idx;

    // Scan from the lowest priority upward so the last hit is the highest-priority requester.
    always_comb begin
        winner  = '0;
        idx     = '0;
        any_req = |req;
        if (mode == ARB_PRIO) begin
            for (int unsigned i = NUM_CH; i > 0; i--) begin
                if (req[ID_W'(i - 1)]) begin
                    winner = ID_W'(i - 1);
                end
            end
        end else begin
            for (int unsigned i = NUM_CH; i > 0; i--) begin
                idx = {1'b0, last_grant} + (ID_W+1)'(i);
                if (idx >= (ID_W+1)'(NUM_CH)) begin
                    idx = idx - (ID_W+1)'(NUM_CH);
                end
                if (req[idx[ID_W-1:0]]) begin
                    winner = idx[ID_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter_n.sv
// N-input AXI-Stream packet arbiter: tlast-locked grants, registered output tagged with source index.
module axis_rr_arbiter_n
    import axis_arb_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 8,
    parameter int ARB_MODE = 0,
    parameter int ID_W     = id_width(NUM_CH)
) (
    input  logic                     axis_clk,
    input  logic                     resetn,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    output logic [NUM_CH-1:0]        s_axis_tready,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]        s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic [ID_W-1:0]          m_axis_tid,
    output logic                     busy
);

    localparam logic MODE = (ARB_MODE != 0) ? ARB_PRIO : ARB_RR;

    arb_state_e        state;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   winner;
    logic              any_req;
    logic              out_ready;
    logic              accept;
    logic [DATA_W-1:0] chan_data [NUM_CH];

    axis_arb_grant_sel #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_grant_sel (
        .req        (s_axis_tvalid),
        .last_grant (last_grant),
        .mode       (MODE),
        .winner     (winner),
        .any_req    (any_req)
    );

    assign busy      = (state == BUSY);
    assign out_ready = ~m_axis_tvalid | m_axis_tready;
    assign accept    = busy & s_axis_tvalid[grant] & out_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign chan_data[k]     = s_axis_tdata[k*DATA_W +: DATA_W];
        assign s_axis_tready[k] = busy & (grant == ID_W'(k)) & out_ready;
    end

    always_ff @(posedge axis_clk) begin
        if (!resetn) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= ID_W'(NUM_CH - 1);
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
        end else begin
            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= chan_data[grant];
                m_axis_tlast  <= s_axis_tlast[grant];
                m_axis_tid    <= grant;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= winner;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && s_axis_tlast[grant]) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter_n.sv
// Randomised scoreboard bench: one round-robin and one fixed-priority arbiter against a packet-level model.
module tb_axis_rr_arbiter_n;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int ID_W   = 2;
    localparam int NCYC   = 4000;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [ID_W-1:0]   id;
    } exp_t;

    logic                     axis_clk = 1'b0;
    logic                     resetn   = 1'b0;
    logic [NUM_CH-1:0]        s_tvalid [2];
    logic [NUM_CH-1:0]        s_tready [2];
    logic [NUM_CH*DATA_W-1:0] s_tdata  [2];
    logic [NUM_CH-1:0]        s_tlast  [2];
    logic                     m_tvalid [2];
    logic                     m_tready [2];
    logic [DATA_W-1:0]        m_tdata  [2];
    logic                     m_tlast  [2];
    logic [ID_W-1:0]          m_tid    [2];
    logic                     busy     [2];

    beat_t       src_q [2][NUM_CH][$];
    exp_t        exp_q [2][$];
    bit          idle_m [2];
    int unsigned last_m [2];
    int unsigned grant_m [2];
    logic [NUM_CH-1:0] hs [2];
    bit          prev_stall [2];
    exp_t        prev_out [2];
    int unsigned rx_cnt [2];
    int unsigned tid_cnt [NUM_CH];
    int          checks = 0;
    int          failures = 0;
    int unsigned vprob = 90;
    int unsigned rprob = 100;
    bit          post_reset = 1'b0;

    always #5 axis_clk = ~axis_clk;

    axis_rr_arbiter_n #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ARB_MODE(0)) u_rr (
        .axis_clk      (axis_clk),
        .resetn        (resetn),
        .s_axis_tvalid (s_tvalid[0]),
        .s_axis_tready (s_tready[0]),
        .s_axis_tdata  (s_tdata[0]),
        .s_axis_tlast  (s_tlast[0]),
        .m_axis_tvalid (m_tvalid[0]),
        .m_axis_tready (m_tready[0]),
        .m_axis_tdata  (m_tdata[0]),
        .m_axis_tlast  (m_tlast[0]),
        .m_axis_tid    (m_tid[0]),
        .busy          (busy[0])
    );

    axis_rr_arbiter_n #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ARB_MODE(1)) u_prio (
        .axis_clk      (axis_clk),
        .resetn        (resetn),
        .s_axis_tvalid (s_tvalid[1]),
        .s_axis_tready (s_tready[1]),
        .s_axis_tdata  (s_tdata[1]),
        .s_axis_tlast  (s_tlast[1]),
        .m_axis_tvalid (m_tvalid[1]),
        .m_axis_tready (m_tready[1]),
        .m_axis_tdata  (m_tdata[1]),
        .m_axis_tlast  (m_tlast[1]),
        .m_axis_tid    (m_tid[1]),
        .busy          (busy[1])
    );

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    // Winner by the arbitration rule: scan from the channel after the last winner, or from 0.
    function automatic int unsigned pick(input int d, input logic [NUM_CH-1:0] req, input int unsigned last);
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            int unsigned c;
            c = (d == 0) ? (last + i) % NUM_CH : i - 1;
            if (req[c]) return c;
        end
        return 0;
    endfunction

    task automatic fill(input int d, input int k);
        int unsigned len;
        beat_t b;
        len = $urandom_range(1, 4);
        for (int unsigned j = 0; j < len; j++) begin
            b.data = DATA_W'($urandom);
            b.last = (j == len - 1);
            src_q[d][k].push_back(b);
        end
    endtask

    task automatic drive(input int d, input bit allow);
        for (int k = 0; k < NUM_CH; k++) begin
            if (hs[d][k]) void'(src_q[d][k].pop_front());
            if (src_q[d][k].size() == 0) fill(d, k);
            s_tvalid[d][k] = allow && ($urandom_range(0, 99) < vprob);
            s_tdata[d][k*DATA_W +: DATA_W] = src_q[d][k][0].data;
            s_tlast[d][k] = src_q[d][k][0].last;
        end
        m_tready[d] = ($urandom_range(0, 99) < rprob);
    endtask

    task automatic model_reset(input int d);
        exp_q[d].delete();
        idle_m[d]     = 1'b1;
        last_m[d]     = NUM_CH - 1;
        grant_m[d]    = 0;
        prev_stall[d] = 1'b0;
    endtask

    // Input-side model step for the edge that follows this negedge.
    task automatic eval(input int d);
        int unsigned g;
        logic [NUM_CH-1:0] er;
        exp_t e;
        hs[d] = s_tvalid[d] & s_tready[d];
        chk("busy", d, 32'(busy[d]), 32'(!idle_m[d]));
        if (idle_m[d]) begin
            chk("idle_tready", d, 32'(s_tready[d]), 32'd0);
            if (|s_tvalid[d]) begin
                g = pick(d, s_tvalid[d], last_m[d]);
                grant_m[d] = g;
                idle_m[d]  = 1'b0;
                for (int j = 0; j < src_q[d][g].size(); j++) begin
                    e.data = src_q[d][g][j].data;
                    e.last = src_q[d][g][j].last;
                    e.id   = ID_W'(g);
                    exp_q[d].push_back(e);
                    if (e.last) break;
                end
            end
        end else begin
            g  = grant_m[d];
            er = NUM_CH'(!m_tvalid[d] || m_tready[d]) << g;
            chk("busy_tready", d, 32'(s_tready[d]), 32'(er));
            if (hs[d][g] && s_tlast[d][g]) begin
                idle_m[d] = 1'b1;
                last_m[d] = g;
            end
        end
    endtask

    // Output monitor: pops the scoreboard on every downstream handshake.
    always @(negedge axis_clk) begin
        if (resetn) begin
            for (int d = 0; d < 2; d++) begin
                if (prev_stall[d]) begin
                    chk("stall_valid", d, 32'(m_tvalid[d]), 32'd1);
                    chk("stall_hold", d, 32'({m_tdata[d], m_tlast[d], m_tid[d]}), 32'(prev_out[d]));
                end
                if (m_tvalid[d] && m_tready[d]) begin
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat dut%0d t=%0t: got %0h with nothing expected",
                                 d, $time, m_tdata[d]);
                    end else begin
                        exp_t e;
                        e = exp_q[d].pop_front();
                        chk("beat_data", d, 32'(m_tdata[d]), 32'(e.data));
                        chk("beat_last", d, 32'(m_tlast[d]), 32'(e.last));
                        chk("beat_tid", d, 32'(m_tid[d]), 32'(e.id));
                        rx_cnt[d]++;
                        if (d == 0) tid_cnt[m_tid[d]]++;
                    end
                end
                prev_stall[d] = m_tvalid[d] && !m_tready[d];
                prev_out[d]   = {m_tdata[d], m_tlast[d], m_tid[d]};
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            hs[d]     = '0;
            rx_cnt[d] = 0;
            s_tdata[d] = '0;
            drive(d, 1'b0);
        end
        for (int k = 0; k < NUM_CH; k++) tid_cnt[k] = 0;

        for (int c = 0; c < NCYC; c++) begin
            case (c / 1000)
                0:       begin vprob = 90;  rprob = 100; end
                1:       begin vprob = 60;  rprob = 50;  end
                2:       begin vprob = 100; rprob = 30;  end
                default: begin vprob = 40;  rprob = 80;  end
            endcase
            @(negedge axis_clk);
            if (!resetn) begin
                for (int d = 0; d < 2; d++) hs[d] = '0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    if (post_reset) begin
                        chk("rst_tvalid", d, 32'(m_tvalid[d]), 32'd0);
                        chk("rst_tdata", d, 32'(m_tdata[d]), 32'd0);
                        chk("rst_tlast", d, 32'(m_tlast[d]), 32'd0);
                        chk("rst_tid", d, 32'(m_tid[d]), 32'd0);
                        chk("rst_tready", d, 32'(s_tready[d]), 32'd0);
                    end
                    eval(d);
                end
                post_reset = 1'b0;
            end
            @(posedge axis_clk);
            #1;
            if (!resetn) begin
                resetn     = 1'b1;
                post_reset = 1'b1;
                for (int d = 0; d < 2; d++) drive(d, 1'b1);
            end else if (c % 600 == 599) begin
                for (int d = 0; d < 2; d++) begin
                    drive(d, 1'b0);
                    model_reset(d);
                end
                resetn = 1'b0;
            end else begin
                for (int d = 0; d < 2; d++) drive(d, 1'b1);
            end
        end

        for (int d = 0; d < 2; d++) chk("progress", d, 32'(rx_cnt[d] >= 200), 32'd1);
        for (int k = 0; k < NUM_CH; k++) chk("rr_coverage", k, 32'(tid_cnt[k] > 0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter_n.md
Name: axis_rr_arbiter_n

Overview:
- Parametrised N-input AXI-Stream packet arbiter. Successor to the 2-input axis_arbiter.
- Merges NUM_CH slave streams onto one master stream with packet-granular (tlast-locked) arbitration.
- Arbitration mode is selectable: round-robin or fixed priority.
- Output is registered and tagged with the source channel index. Sits between multiple packet producers and a shared downstream sink.

Parameters:
- NUM_CH, 4, number of slave channels (2..16).
- DATA_W, 8, tdata width in bits.
- ARB_MODE, 0, 0 = round-robin starting after the last granted channel; 1 = fixed priority, lowest index wins.
- ID_W, max(1,clog2(NUM_CH)), width of m_axis_tid (derived; do not override).

Ports:
- axis_clk  in  1  single clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tready  out  NUM_CH  per-channel ready.
- s_axis_tdata  in  NUM_CH*DATA_W  packed data; channel k occupies bits [k*DATA_W +: DATA_W].
- s_axis_tlast  in  NUM_CH  per-channel end-of-packet.
- m_axis_tvalid  out  1  output valid (registered).
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_W  output data (registered).
- m_axis_tlast  out  1  output end-of-packet (registered).
- m_axis_tid  out  ID_W  index of the source channel for the current beat (registered).
- busy  out  1  high while a packet is locked (state BUSY).

Behaviour:
- Reset (resetn=0 at a rising edge), regardless of in-flight packet:
  - state=IDLE; grant=0; last_grant=NUM_CH-1, so channel 0 wins first in round-robin.
  - m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid all 0.
  - s_axis_tready all 0; busy=0.
  - A partially sent packet is dropped, not completed.
- FSM IDLE:
  - All s_axis_tready=0.
  - If any s_axis_tvalid=1: compute winner, register it into grant, go to BUSY.
  - Round-robin winner: first requester scanning last_grant+1, last_grant+2, ... modulo NUM_CH.
  - Fixed-priority winner: lowest-index requester.
  - If no requester: stay in IDLE.
- FSM BUSY:
  - s_axis_tready[grant] = ~m_axis_tvalid | m_axis_tready. All other readys stay 0.
  - This is a combinational path from m_axis_tready to s_axis_tready.
  - A beat is accepted when s_axis_tvalid[grant] and s_axis_tready[grant] are both 1 at a rising edge.
  - On acceptance, the output register loads tdata, tlast, and tid=grant, and sets m_axis_tvalid=1.
  - On acceptance with tlast=1: set last_grant=grant and go to IDLE.
- Output register:
  - If m_axis_tvalid=1 and m_axis_tready=1 with no new beat loaded that cycle, m_axis_tvalid clears to 0.
  - Registered outputs are held stable while m_axis_tvalid=1 and m_axis_tready=0 (AXIS stability rule).
- Latency and throughput:
  - tvalid sampled in IDLE at edge E. Grant is registered at E. First beat is accepted at E+1 and is valid on m_axis after E+1.
  - Throughput is 1 beat/cycle within a packet while the sink holds m_axis_tready=1.
  - Each packet costs one IDLE arbitration cycle, giving exactly one bubble between consecutive packets.
- Grant lock:
  - The grant is held until tlast is accepted, even if s_axis_tvalid[grant] drops mid-packet. There is no timeout.
  - Requests on other channels never preempt a locked packet.
- Single-beat packet (tvalid and tlast together on the first beat): BUSY lasts one cycle, then IDLE.
- Wrap-around: in round-robin mode, last_grant=NUM_CH-1 wraps the scan to channel 0.
- Requests in IDLE:
  - Simultaneous requests resolve in a single cycle.
  - A request that deasserts before being sampled in IDLE is ignored; there is no request latching.
- Data of non-granted channels is never forwarded.

Decomposition:
- Package axis_arb_pkg:
  - FSM state enum (IDLE, BUSY).
  - ARB_MODE constants (ARB_RR=0, ARB_PRIO=1).
  - clog2-based ID width helper.
- Sub-module axis_arb_grant_sel: purely combinational selector.
  - Inputs: req[NUM_CH], last_grant, mode.
  - Outputs: winner index and any_req.
  - Implements the rotating priority encoder (round-robin) and the lowest-index priority encoder (fixed priority).
  - The top level holds the FSM, the lock logic, and the output register.

Test Plan (NUM_CH=4, DATA_W=8 unless stated):
- Reset mid-packet: ch1 sends 0x11,0x22; resetn=0 for one edge → all outputs 0, state IDLE. Next request from ch1 and ch2 together → ch0 scan order applies: with last_grant=3, ch1 wins.
- Round-robin fairness: ch0..ch3 all hold tvalid, each sends 2-beat packets, m_axis_tready=1 → m_axis_tid sequence 0,0,1,1,2,2,3,3,0,0. Exactly one invalid cycle between packets.
- Fixed priority (ARB_MODE=1): ch0 and ch2 continuously request 3-beat packets → only tid=0 is ever granted. Drop ch0 → ch2 is granted after the current ch0 packet's tlast.
- Backpressure: ch3 sends 0xA0..0xA4 (tlast on 0xA4) while m_axis_tready toggles 1,0,0,1,... → all 5 beats appear in order, unchanged while stalled. s_axis_tready[3]=0 while the output is full and stalled.
- Lock and bubbles: ch1 packet of 4 beats with s_axis_tvalid[1] dropped for 3 cycles after beat 2, ch2 requesting throughout → ch2 is not granted until ch1 tlast is accepted. Output is 4 beats with tid=1, then ch2's packet.
- Single-beat packets and wrap: NUM_CH=2, ch0 and ch1 send 1-beat packets 0x5A and 0xA5 repeatedly → tid alternates 0,1,0,1. busy pulses 1 cycle per packet. Last beat of each has tlast=1.
